pipe_mem_arbiter: RTL and testbench
===================================

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: cycles a memory access may wait for mem_ack_i before it is aborted.
REQ-002 The block SHALL have parameter MAX_DM_STREAK, default 4: maximum consecutive data grants while a fetch is pending.
REQ-003 The block SHALL have ports:
- clk_i  in  1  single clock, all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  instruction fetch request, held until if_ready_o.
- if_addr_i  in  32  fetch address.
- if_ready_o  out  1  one-cycle pulse, fetch complete.
- if_rdata_o  out  32  fetched instruction, valid with if_ready_o.
- dm_read_i  in  1  data load request, held until dm_ready_o.
- dm_write_i  in  1  data store request, held until dm_ready_o.
- dm_addr_i  in  32  data address.
- dm_wdata_i  in  32  store data.
- dm_ready_o  out  1  one-cycle pulse, data access complete.
- dm_rdata_o  out  32  load data, valid with dm_ready_o.
- mem_req_o  out  1  shared memory request.
- mem_we_o  out  1  shared memory write enable.
- mem_addr_o  out  32  shared memory address.
- mem_wdata_o  out  32  shared memory write data.
- mem_ack_i  in  1  memory completion strobe.
- mem_rdata_i  in  32  memory read data, valid with mem_ack_i.
- stall_o  out  1  pipeline freeze request.
- err_o  out  1  sticky timeout flag.

Function
REQ-004 The FSM SHALL have states IDLE, IF_BUSY and DM_BUSY.
REQ-005 In IDLE with a data request (dm_read_i or dm_write_i), the block SHALL go to DM_BUSY unless the fairness rule REQ-007 forces a fetch.
REQ-006 In IDLE with only if_req_i high, the block SHALL go to IF_BUSY.
REQ-007 When if_req_i is high and the streak counter equals MAX_DM_STREAK, the block SHALL grant the fetch even if a data request is pending.
REQ-008 The streak counter SHALL increment on each data grant, saturate at MAX_DM_STREAK, and clear on each fetch grant.
REQ-009 On a grant, the block SHALL register mem_addr_o, mem_we_o and mem_wdata_o from the granted requester.
- mem_we_o is 1 only for dm_write_i.
- dm_write_i has precedence over dm_read_i if both are high.
REQ-010 In the BUSY states, mem_req_o SHALL be 1 and mem_addr_o, mem_we_o and mem_wdata_o SHALL be held constant.
REQ-011 On mem_ack_i in a BUSY state, the block SHALL on the next edge:
- capture mem_rdata_i into the owner's rdata register;
- pulse the owner's ready output for exactly one cycle;
- drop mem_req_o;
- return to IDLE.
REQ-012 Rdata registers SHALL hold their value until the next completion for that requester; for stores, dm_rdata_o is unchanged.
REQ-013 Access latency SHALL be: grant edge, memory ack cycle(s), then ready pulse on the following edge; minimum 2 cycles from request to ready when the memory acks in the first BUSY cycle.
REQ-014 A new grant SHALL occur no earlier than the cycle after a ready pulse, so there is one IDLE cycle between accesses.
REQ-015 A per-access wait counter SHALL clear on grant and increment each BUSY cycle without mem_ack_i.
REQ-016 When the wait counter reaches TIMEOUT-1 without an ack, the block SHALL on the next edge:
- set err_o;
- drop mem_req_o;
- pulse the owner's ready with its rdata set to 32'h0;
- return to IDLE.
REQ-017 err_o SHALL stay set until reset.
REQ-018 mem_ack_i in IDLE SHALL be ignored.
REQ-019 stall_o SHALL be combinational: (if_req_i and not if_ready_o) or ((dm_read_i or dm_write_i) and not dm_ready_o).
REQ-020 Request deassertion while BUSY is illegal; the block SHALL still complete the access and pulse ready.

Reset
REQ-021 While rst_i is low, the block SHALL be in IDLE with all of these cleared: streak counter, wait counter, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ready_o, dm_ready_o, if_rdata_o, dm_rdata_o, err_o.
REQ-022 Reset asserted mid-access SHALL abort the access immediately with no ready pulse; the first grant after reset release SHALL occur on the first edge with rst_i high.

Verification
REQ-023 Fetch with immediate ack: if_req_i=1, if_addr_i=32'h0000_0004, ack with mem_rdata_i=32'h2001_0005 one cycle after grant -> mem_req_o high 1 cycle, if_ready_o pulse with if_rdata_o=32'h2001_0005, stall_o low in the ready cycle.
REQ-024 Simultaneous requests: if_req_i and dm_read_i both high at the same edge, addr 32'h10 -> data granted first; fetch granted in the cycle after dm_ready_o.
REQ-025 Starvation: dm_write_i held with back-to-back stores and if_req_i high -> after 4 data grants the 5th grant is the fetch and the streak counter reads 0.
REQ-026 Timeout: dm_read_i with no mem_ack_i -> after 16 BUSY cycles, dm_ready_o pulses with dm_rdata_o=0, err_o=1 and stays 1 across later accesses.
REQ-027 Reset mid-access: rst_i low during IF_BUSY -> mem_req_o=0 asynchronously, no if_ready_o pulse, re-grant of held if_req_i on the first edge after release.
REQ-028 Stray ack: mem_ack_i pulse in IDLE -> no ready pulse and no state change.

Source files
------------

// File: rtl/pipe_mem_arbiter_if.sv
// Bundle of fetch, data and shared-memory handshake signals around the arbiter.
// slave is the arbiter's view; master is the pipeline/memory side that drives requests and acks.
interface pipe_mem_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ready_o;
    logic [31:0] if_rdata_o;
    logic        dm_read_i;
    logic        dm_write_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_ready_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        err_o;

    modport slave (
        input  if_req_i, if_addr_i, dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
               mem_ack_i, mem_rdata_i,
        output if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
               mem_ack_i, mem_rdata_i,
        input  if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
    );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory, with fetch anti-starvation and a timeout.
// Latency: grant edge, >=1 BUSY cycle until ack/timeout, ready pulse the edge after.
// Backpressure: requesters hold until their ready pulse; stall_o freezes the pipe meanwhile.
module pipe_mem_arbiter #(
    parameter int TIMEOUT       = 16,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    pipe_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          dm_req;
    logic          finish;
    logic [31:0]   fin_rdata;

    assign dm_req = bus.dm_read_i | bus.dm_write_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        finish      = 1'b0;
        fin_rdata   = '0;

        case (state_q)
            IDLE: begin
                // The finishing requester still holds its request during the ready cycle,
                // so no grant is made until that pulse has gone.
                if (!if_ready_q && !dm_ready_q) begin
                    if (bus.if_req_i && (!dm_req || streak_q == STREAK_MAX)) begin
                        state_d     = IF_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr_i;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                        wait_d      = '0;
                    end else if (dm_req) begin
                        state_d     = DM_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.dm_write_i;
                        mem_addr_d  = bus.dm_addr_i;
                        mem_wdata_d = bus.dm_wdata_i;
                        streak_d    = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                        wait_d      = '0;
                    end
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (bus.mem_ack_i) begin
                    finish    = 1'b1;
                    fin_rdata = bus.mem_rdata_i;
                end else if (wait_q == WAIT_LAST) begin
                    finish    = 1'b1;
                    err_d     = 1'b1;
                    fin_rdata = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            if (state_q == IF_BUSY) begin
                if_ready_d = 1'b1;
                if_rdata_d = fin_rdata;
            end else begin
                dm_ready_d = 1'b1;
                // A completed store leaves load data alone; an aborted access returns zero.
                if (!mem_we_q || !bus.mem_ack_i) dm_rdata_d = fin_rdata;
            end
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_ready_o  = if_ready_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_ready_o  = dm_ready_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.err_o       = err_q;
    assign bus.stall_o     = (bus.if_req_i & ~if_ready_q) | (dm_req & ~dm_ready_q);
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed cycle-table bench for pipe_mem_arbiter plus sequences for starvation, timeout and reset.
module tb_pipe_mem_arbiter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   nerr  = 0;
    int   nchk  = 0;

    pipe_mem_arbiter_if bus();

    pipe_mem_arbiter #(.TIMEOUT(16), .MAX_DM_STREAK(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         ir;
        logic [31:0]  ia;
        logic         rd;
        logic         wr;
        logic [31:0]  da;
        logic [31:0]  dw;
        logic         ack;
        logic [31:0]  mr;
        logic [133:0] exp;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input int ir, input logic [31:0] ia, input int rd, input int wr,
                                input logic [31:0] da, input logic [31:0] dw, input int ack,
                                input logic [31:0] mr, input int q, input int we,
                                input logic [31:0] ma, input logic [31:0] mw, input int ifr,
                                input logic [31:0] ifd, input int dmr, input logic [31:0] dmd,
                                input int st, input int er);
        vec_t v;
        v.ir  = ir[0];
        v.ia  = ia;
        v.rd  = rd[0];
        v.wr  = wr[0];
        v.da  = da;
        v.dw  = dw;
        v.ack = ack[0];
        v.mr  = mr;
        v.exp = {q[0], we[0], ma, mw, ifr[0], ifd, dmr[0], dmd, st[0], er[0]};
        return v;
    endfunction

    function automatic logic [133:0] outs();
        return {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_ready_o,
                bus.if_rdata_o, bus.dm_ready_o, bus.dm_rdata_o, bus.stall_o, bus.err_o};
    endfunction

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.dm_read_i   = 1'b0;
        bus.dm_write_i  = 1'b0;
        bus.dm_addr_i   = '0;
        bus.dm_wdata_i  = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_inputs();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (bus.mem_req_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for a grant, acks it in the first BUSY cycle, returns at the ready-cycle negedge.
    task automatic serve(input logic [31:0] rdata, output logic we, output int streak, output bit ok);
        we     = 1'b0;
        streak = -1;
        wait_req(ok);
        if (ok) begin
            we              = bus.mem_we_o;
            streak          = int'(dut.streak_q);
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = rdata;
            @(negedge clk_i);
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic we;
        int   streak;
        bit   ok;
        int   busy;
        logic [4:0] exp_we;
        int   exp_streak [5];

        //           ir  ia      rd wr da     dw            ack mr             q we ma      mw            ifr ifd           dmr dmd           st er
        tbl[0]  = mk(1, 'h4,    0, 0, 'h0,  'h0,          0, 'h0,           0, 0, 'h0,   'h0,          0, 'h0,          0, 'h0,          1, 0);
        tbl[1]  = mk(1, 'h4,    0, 0, 'h0,  'h0,          1, 'h2001_0005,   1, 0, 'h4,   'h0,          0, 'h0,          0, 'h0,          1, 0);
        tbl[2]  = mk(1, 'h4,    0, 0, 'h0,  'h0,          0, 'h0,           0, 0, 'h4,   'h0,          1, 'h2001_0005,  0, 'h0,          0, 0);
        tbl[3]  = mk(0, 'h0,    0, 0, 'h0,  'h0,          0, 'h0,           0, 0, 'h4,   'h0,          0, 'h2001_0005,  0, 'h0,          0, 0);
        tbl[4]  = mk(1, 'h100,  1, 0, 'h10, 'h0,          0, 'h0,           0, 0, 'h4,   'h0,          0, 'h2001_0005,  0, 'h0,          1, 0);
        tbl[5]  = mk(1, 'h100,  1, 0, 'h10, 'h0,          0, 'h0,           1, 0, 'h10,  'h0,          0, 'h2001_0005,  0, 'h0,          1, 0);
        tbl[6]  = mk(1, 'h100,  1, 0, 'h10, 'h0,          1, 'hDEAD_0010,   1, 0, 'h10,  'h0,          0, 'h2001_0005,  0, 'h0,          1, 0);
        tbl[7]  = mk(1, 'h100,  1, 0, 'h10, 'h0,          0, 'h0,           0, 0, 'h10,  'h0,          0, 'h2001_0005,  1, 'hDEAD_0010, 1, 0);
        tbl[8]  = mk(1, 'h100,  0, 0, 'h0,  'h0,          0, 'h0,           0, 0, 'h10,  'h0,          0, 'h2001_0005,  0, 'hDEAD_0010, 1, 0);
        tbl[9]  = mk(1, 'h100,  0, 0, 'h0,  'h0,          1, 'h1111_2222,   1, 0, 'h100, 'h0,          0, 'h2001_0005,  0, 'hDEAD_0010, 1, 0);
        tbl[10] = mk(1, 'h100,  0, 0, 'h0,  'h0,          0, 'h0,           0, 0, 'h100, 'h0,          1, 'h1111_2222,  0, 'hDEAD_0010, 0, 0);
        tbl[11] = mk(0, 'h0,    0, 0, 'h0,  'h0,          0, 'h0,           0, 0, 'h100, 'h0,          0, 'h1111_2222,  0, 'hDEAD_0010, 0, 0);
        tbl[12] = mk(0, 'h0,    0, 0, 'h0,  'h0,          1, 'hBAD0_BAD0,   0, 0, 'h100, 'h0,          0, 'h1111_2222,  0, 'hDEAD_0010, 0, 0);
        tbl[13] = mk(0, 'h0,    0, 0, 'h0,  'h0,          0, 'h0,           0, 0, 'h100, 'h0,          0, 'h1111_2222,  0, 'hDEAD_0010, 0, 0);
        tbl[14] = mk(0, 'h0,    0, 1, 'h20, 'hCAFE_0001,  0, 'h0,           0, 0, 'h100, 'h0,          0, 'h1111_2222,  0, 'hDEAD_0010, 1, 0);
        tbl[15] = mk(0, 'h0,    0, 1, 'h20, 'hCAFE_0001,  1, 'h5555_AAAA,   1, 1, 'h20,  'hCAFE_0001,  0, 'h1111_2222,  0, 'hDEAD_0010, 1, 0);
        tbl[16] = mk(0, 'h0,    0, 1, 'h20, 'hCAFE_0001,  0, 'h0,           0, 1, 'h20,  'hCAFE_0001,  0, 'h1111_2222,  1, 'hDEAD_0010, 0, 0);
        tbl[17] = mk(0, 'h0,    0, 0, 'h0,  'h0,          0, 'h0,           0, 1, 'h20,  'hCAFE_0001,  0, 'h1111_2222,  0, 'hDEAD_0010, 0, 0);

        // Reset state
        clear_inputs();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("reset_state", outs(), 134'd0);
        rst_i = 1'b1;

        // Cycle table: fetch with immediate ack, simultaneous requests, stray ack, store
        for (int k = 0; k < 18; k++) begin
            @(posedge clk_i);
            #1;
            bus.if_req_i    = tbl[k].ir;
            bus.if_addr_i   = tbl[k].ia;
            bus.dm_read_i   = tbl[k].rd;
            bus.dm_write_i  = tbl[k].wr;
            bus.dm_addr_i   = tbl[k].da;
            bus.dm_wdata_i  = tbl[k].dw;
            bus.mem_ack_i   = tbl[k].ack;
            bus.mem_rdata_i = tbl[k].mr;
            @(negedge clk_i);
            chk($sformatf("table_cycle_%0d", k), outs(), tbl[k].exp);
        end

        // Starvation: back-to-back stores with a fetch waiting
        apply_reset();
        bus.dm_write_i = 1'b1;
        bus.dm_addr_i  = 32'h30;
        bus.dm_wdata_i = 32'h0000_0777;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h200;
        exp_we     = 5'b01111;
        exp_streak = '{1, 2, 3, 4, 0};
        for (int g = 0; g < 5; g++) begin
            serve(32'h0000_1000 + 32'(g), we, streak, ok);
            chk($sformatf("starve_grant_seen_%0d", g), 134'(ok), 134'd1);
            chk($sformatf("starve_grant_we_%0d", g), 134'(we), 134'(exp_we[g]));
            chk($sformatf("starve_streak_%0d", g), 134'(streak), 134'(exp_streak[g]));
        end
        chk("starve_fetch_ready", {bus.if_ready_o, bus.if_rdata_o}, {1'b1, 32'h0000_1004});
        clear_inputs();

        // Timeout: one good load, then an unanswered load
        apply_reset();
        bus.dm_read_i = 1'b1;
        bus.dm_addr_i = 32'h40;
        serve(32'h1234_5678, we, streak, ok);
        chk("pre_load_grant", 134'(ok), 134'd1);
        chk("pre_load_done", {bus.dm_ready_o, bus.dm_rdata_o, bus.err_o}, {1'b1, 32'h1234_5678, 1'b0});
        bus.dm_addr_i = 32'h44;
        wait_req(ok);
        chk("timeout_grant", 134'(ok), 134'd1);
        busy = 0;
        if (ok) begin
            busy = 1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk_i);
                if (bus.mem_req_o !== 1'b1) break;
                busy++;
            end
        end
        chk("timeout_busy_cycles", 134'(busy), 134'd16);
        chk("timeout_abort", {bus.mem_req_o, bus.dm_ready_o, bus.dm_rdata_o, bus.err_o},
            {1'b0, 1'b1, 32'h0, 1'b1});
        bus.dm_read_i = 1'b0;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h300;
        serve(32'hABCD_0123, we, streak, ok);
        chk("post_timeout_fetch", {bus.if_ready_o, bus.if_rdata_o, bus.err_o}, {1'b1, 32'hABCD_0123, 1'b1});
        bus.if_req_i = 1'b0;
        @(negedge clk_i);
        chk("err_sticky", 134'(bus.err_o), 134'd1);

        // Reset in the middle of a fetch
        apply_reset();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h80;
        wait_req(ok);
        chk("rst_mid_grant", 134'(ok), 134'd1);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("rst_async_clear", outs(), 134'd2);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_no_ready", outs(), 134'd2);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_regrant", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h80});
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h5A5A_5A5A;
        @(negedge clk_i);
        bus.mem_ack_i   = 1'b0;
        chk("rst_regrant_done", {bus.if_ready_o, bus.if_rdata_o}, {1'b1, 32'h5A5A_5A5A});
        clear_inputs();
        @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
